hint_unpack: RTL and testbench

- Verify-path decoder for the hint field that the signing path's hint generator emits as 64-bit words.
- Buffers the omega+K hint bytes, checks that they are well-formed, then streams per-coefficient hint bits, four coefficients per beat, to the use-hint stage.
- Malformed encodings raise a sticky reject.

---
 rtl/hint_unpack_pkg.sv | 56 +++++
 rtl/hint_unpack_if.sv | 31 +++
 rtl/hint_lane_match.sv | 32 +++
 rtl/hint_unpack.sv | 176 +++++++++++++++++
 tb/tb_hint_unpack.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hint_unpack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hint_unpack_pkg                                                    |
// | Level constants, encodings and helpers shared by the hint decoder. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package hint_unpack_pkg;

    localparam int unsigned c_Q            = 8380417;
    localparam int unsigned c_GAMMA2_L2    = (c_Q - 1) / 88;
    localparam int unsigned c_GAMMA2_L35   = (c_Q - 1) / 32;
    localparam int          c_MAX_WORDS    = 11;

    localparam logic [2:0]  c_SEC_L2       = 3'd2;
    localparam logic [2:0]  c_SEC_L3       = 3'd3;

    typedef enum logic [1:0] {
        LVL2 = 2'd0,
        LVL3 = 2'd1,
        LVL5 = 2'd2
    } lvl_e;

    typedef struct packed {
        logic [6:0] omega;
        logic [3:0] k;
        logic [3:0] words;
    } lvl_cfg_t;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_CNT   = 3'd1,
        S_EMIT  = 3'd2,
        S_REJ   = 3'd3
`ifdef HINTUNPACK_STRICT_EN
        , S_ORDER = 3'd4
`endif
    } state_e;

    function automatic lvl_e decode_lvl(input logic [2:0] sec);
        case (sec)
            c_SEC_L2: return LVL2;
            c_SEC_L3: return LVL3;
            default:  return LVL5;
        endcase
    endfunction

    function automatic lvl_cfg_t lvl_cfg(input lvl_e lvl);
        case (lvl)
            LVL2:    return '{omega: 7'd80, k: 4'd4, words: 4'd11};
            LVL3:    return '{omega: 7'd55, k: 4'd6, words: 4'd8};
            default: return '{omega: 7'd75, k: 4'd8, words: 4'd11};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hint_unpack_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hint_unpack_if                                                     |
// | Hint-word input and per-coefficient hint-bit output bundle.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface hint_unpack_if #(
    parameter int W        = 64,
    parameter int OUTPUT_W = 4
);
    logic [2:0]          sec_lvl;
    logic [W-1:0]        hint_i;
    logic                hint_valid_i;
    logic                hint_ready_i;
    logic [OUTPUT_W-1:0] h_o;
    logic                h_valid_o;
    logic                h_ready_o;
    logic                reject_o;
    logic                done_o;

    modport slave (
        input  sec_lvl, hint_i, hint_valid_i, h_ready_o,
        output hint_ready_i, h_o, h_valid_o, reject_o, done_o
    );

    modport master (
        output sec_lvl, hint_i, hint_valid_i, h_ready_o,
        input  hint_ready_i, h_o, h_valid_o, reject_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/hint_lane_match.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hint_lane_match                                                    |
// | Compares an address window against ctr..ctr+LANES-1.               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hint_lane_match #(
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  wire logic [8*LANES-1:0] i_addr,
    input  wire logic [LANES-1:0]   i_vld,
    input  wire logic [7:0]         i_ctr,
    output logic      [LANES-1:0]   o_h,
    output logic      [CW-1:0]      o_cnt
);
    always_comb begin
        o_h   = '0;
        o_cnt = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_vld[k] && (i_addr[8*k +: 8] == i_ctr + 8'(j))) begin
                    o_h[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < LANES; j++) begin
            o_cnt = o_cnt + CW'(o_h[j]);
        end
    end
endmodule
`default_nettype wire

// File: rtl/hint_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hint_unpack                                                        |
// | Buffers packed hint bytes, validates them, streams hint bits.      |
// | Optional address-order checking: HINTUNPACK_STRICT_EN.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hint_unpack
    import hint_unpack_pkg::*;
#(
    parameter int OUTPUT_W = 4,
    parameter int W        = 64
) (
    input  wire logic    clk,
    input  wire logic    rst,
    hint_unpack_if.slave bus
);
    localparam int         c_BUF_BITS = c_MAX_WORDS * W;
    localparam int         c_MW       = $clog2(OUTPUT_W + 1);
    localparam logic [7:0] c_CTR_LAST = 8'(256 - OUTPUT_W);

    function automatic logic [7:0] buf_byte(input logic [c_BUF_BITS-1:0] b, input logic [6:0] n);
        return b[8*int'(n) +: 8];
    endfunction

    state_e                r_state, w_state_nxt;
    logic [c_BUF_BITS-1:0] r_buf;
    lvl_e                  r_lvl, w_lvl;
    lvl_cfg_t              w_cfg;
    logic [3:0]            r_wcnt, r_p;
    logic [6:0]            r_ptr;
    logic [7:0]            r_ctr;
    logic                  r_done;
    logic                  w_acc, w_beat, w_last_word, w_last_p, w_cnt_bad;
    logic [7:0]            w_cnt_cur, w_cnt_prev;
    logic [8*OUTPUT_W-1:0] w_win;
    logic [OUTPUT_W-1:0]   w_win_vld, w_h;
    logic [c_MW-1:0]       w_mcnt;

    // Level is taken live only for the first word, then held.
    assign w_lvl       = (r_state == S_LOAD && r_wcnt == 4'd0) ? decode_lvl(bus.sec_lvl) : r_lvl;
    assign w_cfg       = lvl_cfg(w_lvl);
    assign w_acc       = bus.hint_valid_i && bus.hint_ready_i;
    assign w_beat      = (r_state == S_EMIT) && bus.h_ready_o;
    assign w_last_word = (r_wcnt == w_cfg.words - 4'd1);
    assign w_last_p    = (r_p == w_cfg.k - 4'd1);
    assign w_cnt_cur   = buf_byte(r_buf, w_cfg.omega + 7'(r_p));
    assign w_cnt_prev  = (r_p == 4'd0) ? 8'd0 : buf_byte(r_buf, w_cfg.omega + 7'(r_p) - 7'd1);
    assign w_cnt_bad   = (w_cnt_cur < w_cnt_prev) || (w_cnt_cur > {1'b0, w_cfg.omega});

    for (genvar k = 0; k < OUTPUT_W; k++) begin : g_win
        logic [6:0] w_idx;
        assign w_idx            = r_ptr + 7'(k);
        assign w_win[8*k +: 8]  = buf_byte(r_buf, w_idx);
        assign w_win_vld[k]     = ({1'b0, w_idx} < w_cnt_cur);
    end

    hint_lane_match #(.LANES(OUTPUT_W), .CW(c_MW)) u_match (
        .i_addr (w_win),
        .i_vld  (w_win_vld),
        .i_ctr  (r_ctr),
        .o_h    (w_h),
        .o_cnt  (w_mcnt)
    );

`ifdef HINTUNPACK_STRICT_EN
    logic [6:0] r_b;
    logic [7:0] w_last_cnt, w_ab, w_ab_prev;
    logic       w_first, w_ord_bad;

    // A byte opens a poly when it sits at some earlier poly's cumulative count.
    always_comb begin
        w_first = (r_b == 7'd0);
        for (int q = 0; q < 7; q++) begin
            if ((4'(q) < w_cfg.k - 4'd1) &&
                (buf_byte(r_buf, w_cfg.omega + 7'(q)) == {1'b0, r_b})) begin
                w_first = 1'b1;
            end
        end
    end

    assign w_last_cnt = buf_byte(r_buf, w_cfg.omega + 7'(w_cfg.k) - 7'd1);
    assign w_ab       = buf_byte(r_buf, r_b);
    assign w_ab_prev  = (r_b == 7'd0) ? 8'd0 : buf_byte(r_buf, r_b - 7'd1);
    assign w_ord_bad  = ({1'b0, r_b} < w_last_cnt) ? (!w_first && (w_ab <= w_ab_prev))
                                                    : (w_ab != 8'd0);
`endif

    assign bus.hint_ready_i = rst && (r_state == S_LOAD);
    assign bus.h_valid_o    = (r_state == S_EMIT);
    assign bus.h_o          = w_h;
    assign bus.reject_o     = (r_state == S_REJ);
    assign bus.done_o       = r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_LOAD;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: if (w_acc && w_last_word) w_state_nxt = S_CNT;
            S_CNT: begin
                if (w_cnt_bad) w_state_nxt = S_REJ;
`ifdef HINTUNPACK_STRICT_EN
                else if (w_last_p) w_state_nxt = S_ORDER;
`else
                else if (w_last_p) w_state_nxt = S_EMIT;
`endif
            end
`ifdef HINTUNPACK_STRICT_EN
            S_ORDER: begin
                if (w_ord_bad) w_state_nxt = S_REJ;
                else if (r_b == w_cfg.omega - 7'd1) w_state_nxt = S_EMIT;
            end
`endif
            S_EMIT: if (w_beat && r_ctr == c_CTR_LAST && w_last_p) w_state_nxt = S_LOAD;
            S_REJ:  w_state_nxt = S_REJ;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf  <= '0;
            r_lvl  <= LVL2;
            r_wcnt <= 4'd0;
            r_p    <= 4'd0;
            r_ptr  <= 7'd0;
            r_ctr  <= 8'd0;
            r_done <= 1'b0;
`ifdef HINTUNPACK_STRICT_EN
            r_b    <= 7'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_acc) begin
                        r_buf[W*int'(r_wcnt) +: W] <= bus.hint_i;
                        r_lvl  <= w_lvl;
                        r_wcnt <= w_last_word ? 4'd0 : r_wcnt + 4'd1;
                    end
                end
                S_CNT: begin
                    r_p   <= w_last_p ? 4'd0 : r_p + 4'd1;
                    r_ptr <= 7'd0;
                    r_ctr <= 8'd0;
`ifdef HINTUNPACK_STRICT_EN
                    r_b   <= 7'd0;
`endif
                end
`ifdef HINTUNPACK_STRICT_EN
                S_ORDER: r_b <= r_b + 7'd1;
`endif
                S_EMIT: begin
                    if (w_beat) begin
                        if (r_ctr == c_CTR_LAST) begin
                            // Skips any unmatched entries left in this poly.
                            r_ptr <= w_cnt_cur[6:0];
                            r_ctr <= 8'd0;
                            r_p   <= w_last_p ? 4'd0 : r_p + 4'd1;
                            r_done <= w_last_p;
                        end else begin
                            r_ptr <= r_ptr + 7'(w_mcnt);
                            r_ctr <= r_ctr + 8'(OUTPUT_W);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hint_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hint_unpack                                                     |
// | Directed self-checking bench for hint_unpack.                      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_hint_unpack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hint_unpack_if #(.W(64), .OUTPUT_W(4)) bus ();
    hint_unpack #(.OUTPUT_W(4), .W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] mem [0:87];
    logic [3:0] beats [0:511];
    int nbeats, ndone, nunstable, nvalid, nready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 88; i++) mem[i] = 8'd0;
    endtask

    task automatic load(input int nwords, input logic [2:0] lvl, input logic [2:0] lvl_after,
                        input bit toggle);
        int sent = 0;
        int cyc  = 0;
        logic [63:0] w;
        bus.sec_lvl = lvl;
        while (sent < nwords && cyc < 200) begin
            @(negedge clk);
            if (sent > 0) bus.sec_lvl = lvl_after;
            for (int b = 0; b < 8; b++) w[8*b +: 8] = mem[8*sent + b];
            bus.hint_i       = w;
            bus.hint_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (bus.hint_valid_i && bus.hint_ready_i) sent++;
            cyc++;
        end
        @(negedge clk);
        bus.hint_valid_i = 1'b0;
        chk("load_words", sent, nwords);
    endtask

    task automatic emit(input bit stall, input int budget);
        bit pend = 1'b0;
        logic [3:0] ph = 4'd0;
        nbeats = 0; ndone = 0; nunstable = 0;
        for (int c = 0; c < budget && ndone == 0; c++) begin
            @(negedge clk);
            bus.h_ready_o = stall ? (c % 2 == 1) : 1'b1;
            #1;
            if (bus.done_o) ndone++;
            if (pend && (!bus.h_valid_o || bus.h_o !== ph)) nunstable++;
            pend = bus.h_valid_o && !bus.h_ready_o;
            ph   = bus.h_o;
            if (bus.h_valid_o && bus.h_ready_o) begin
                if (nbeats < 512) beats[nbeats] = bus.h_o;
                nbeats++;
            end
        end
        @(negedge clk);
        bus.h_ready_o = 1'b1;
    endtask

    task automatic watch(input int n);
        nvalid = 0; nready = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            if (bus.h_valid_o) nvalid++;
            if (bus.hint_ready_i) nready++;
        end
    endtask

    function automatic int count_nz(input int skip_a, input int skip_b);
        int n = 0;
        for (int i = 0; i < nbeats && i < 512; i++)
            if (i != skip_a && i != skip_b && beats[i] != 4'd0) n++;
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic setup_a();
        clear_mem();
        mem[0] = 8'd3; mem[1] = 8'd5; mem[2] = 8'd6; mem[3] = 8'd7;
        for (int p = 0; p < 4; p++) mem[80 + p] = 8'd4;
    endtask

    initial begin
        int seen;
        bus.sec_lvl      = 3'd2;
        bus.hint_i       = 64'd0;
        bus.hint_valid_i = 1'b0;
        bus.h_ready_o    = 1'b1;
        #2 rst = 1'b0;
        #2;
        chk("rst_hint_ready", bus.hint_ready_i, 0);
        chk("rst_h_valid", bus.h_valid_o, 0);
        chk("rst_reject", bus.reject_o, 0);
        chk("rst_done", bus.done_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // lvl2 basic decode; sec_lvl changed after first word must be ignored
        setup_a();
        load(11, 3'd2, 3'd3, 1'b0);
        emit(1'b0, 3000);
        chk("a_beats", nbeats, 256);
        chk("a_beat0", beats[0], 4'b1000);
        chk("a_beat1", beats[1], 4'b1110);
        chk("a_rest_zero", count_nz(0, 1), 0);
        chk("a_done", ndone, 1);
        chk("a_reject", bus.reject_o, 0);
        chk("a_ready_again", bus.hint_ready_i, 1);

        // lvl2 non-monotone counts
        setup_a();
        mem[81] = 8'd2;
        load(11, 3'd2, 3'd2, 1'b0);
        watch(30);
        chk("b_reject", bus.reject_o, 1);
        chk("b_valid_cycles", nvalid, 0);
        chk("b_ready_cycles", nready, 0);
        do_reset();
        chk("b_reject_cleared", bus.reject_o, 0);

        // lvl2 count exceeding omega
        setup_a();
        for (int p = 0; p < 4; p++) mem[80 + p] = 8'd81;
        load(11, 3'd2, 3'd2, 1'b0);
        watch(30);
        chk("c_reject", bus.reject_o, 1);
        chk("c_valid_cycles", nvalid, 0);
        do_reset();

        // lvl5 (encoded as 7) with duplicate addresses
        clear_mem();
        mem[0] = 8'd9; mem[1] = 8'd9;
        for (int p = 0; p < 8; p++) mem[75 + p] = 8'd2;
        load(11, 3'd7, 3'd2, 1'b0);
`ifdef HINTUNPACK_STRICT_EN
        watch(120);
        chk("d_reject", bus.reject_o, 1);
        chk("d_valid_cycles", nvalid, 0);
        do_reset();
`else
        emit(1'b0, 3000);
        chk("d_beats", nbeats, 512);
        chk("d_beat2", beats[2], 4'b0010);
        chk("d_rest_zero", count_nz(2, 2), 0);
        chk("d_done", ndone, 1);
`endif

        // lvl3 with input gaps and output backpressure
        clear_mem();
        mem[0] = 8'd252; mem[1] = 8'd255;
        mem[60] = 8'd2;
        load(8, 3'd3, 3'd2, 1'b1);
        emit(1'b1, 3000);
        chk("e_beats", nbeats, 384);
        chk("e_last", beats[383], 4'b1001);
        chk("e_rest_zero", count_nz(383, 383), 0);
        chk("e_stable", nunstable, 0);
        chk("e_done", ndone, 1);

        // reset in the middle of emission, then a clean lvl2 run
        setup_a();
        load(11, 3'd2, 3'd2, 1'b0);
        seen = 0;
        for (int c = 0; c < 300 && seen < 5; c++) begin
            @(negedge clk);
            #1;
            if (bus.h_valid_o) seen++;
        end
        chk("f_emitting", seen, 5);
        #2 rst = 1'b0;
        #1;
        chk("f_valid_in_rst", bus.h_valid_o, 0);
        chk("f_ready_in_rst", bus.hint_ready_i, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        load(11, 3'd2, 3'd2, 1'b0);
        emit(1'b0, 3000);
        chk("f_beats", nbeats, 256);
        chk("f_beat0", beats[0], 4'b1000);
        chk("f_beat1", beats[1], 4'b1110);
        chk("f_done", ndone, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
